// File: rtl/ntt_pkg.sv
// Shared NTT definitions: sequencer FSM encoding and default transform/latency sizing.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } ntt_state_e;

    localparam int DEF_LOG_N       = 10;
    localparam int DEF_BF_LATENCY  = 10;
    localparam int DEF_MEM_LATENCY = 1;

endpackage

// File: rtl/ntt_stage_controller_if.sv
// Control/address bus between the stage sequencer and the core FSM, coefficient RAM and twiddle ROM.
interface ntt_stage_controller_if #(
    parameter int LOG_N = ntt_pkg::DEF_LOG_N
);
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG_N-1:0] rd_addr_a;
    logic [LOG_N-1:0] rd_addr_b;
    logic [LOG_N-1:0] tw_addr;
    logic             wr_en;
    logic [LOG_N-1:0] wr_addr_a;
    logic [LOG_N-1:0] wr_addr_b;

    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_addr_delay.sv
// Fixed-depth delay line carrying read strobe + address pair forward to become the write-back strobe.
module ntt_addr_delay #(
    parameter int DEPTH = 11,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] dat_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] dat_out
);
    logic [DEPTH:1]            vld_pipe;
    logic [DEPTH:1][WIDTH-1:0] dat_pipe;

    // Data is cleared as well so idle write addresses read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= vld_in;
            dat_pipe[1] <= dat_in;
            for (int j = 2; j <= DEPTH; j++) begin
                vld_pipe[j] <= vld_pipe[j-1];
                dat_pipe[j] <= dat_pipe[j-1];
            end
        end
    end

    assign vld_out = vld_pipe[DEPTH];
    assign dat_out = dat_pipe[DEPTH];
endmodule

// File: rtl/ntt_stage_controller.sv
// In-place Cooley-Tukey stage sequencer: one butterfly read per cycle, pipeline drain between stages,
// and write-back addresses delayed by exactly MEM_LATENCY+BF_LATENCY cycles.
module ntt_stage_controller
    import ntt_pkg::*;
#(
    parameter int LOG_N       = DEF_LOG_N,
    parameter int BF_LATENCY  = DEF_BF_LATENCY,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input logic                    clk,
    input logic                    rst_n,
    ntt_stage_controller_if.master bus
);
    localparam int D  = MEM_LATENCY + BF_LATENCY;
    localparam int SW = $clog2(LOG_N);
    localparam int KW = LOG_N - 1;
    localparam int DW = (D > 1) ? $clog2(D) : 1;

    localparam logic [KW-1:0]    K_LAST = '1;
    localparam logic [SW-1:0]    S_LAST = SW'(LOG_N - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(D - 1);
    localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);

    ntt_state_e state, nstate;
    logic [SW-1:0] s;
    logic [KW-1:0] k;
    logic [DW-1:0] dcnt;

    logic busy, done, rd_en;
    logic [LOG_N-1:0] addr_a, addr_b, addr_tw;
    logic [LOG_N-1:0] kx, tsz, grp, base;
    int lt;
    logic [2*LOG_N-1:0] wr_pair;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:   if (bus.start) nstate = ST_ISSUE;
            ST_ISSUE:  if (k == K_LAST) nstate = ST_DRAIN;
            ST_DRAIN:  if (dcnt == D_LAST) nstate = (s == S_LAST) ? ST_FINISH : ST_ISSUE;
            ST_FINISH: nstate = ST_IDLE;
            default:   nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == ST_ISSUE) || (state == ST_DRAIN);
        done  = (state == ST_FINISH);
        rd_en = (state == ST_ISSUE);
    end

    // k wraps to zero naturally after N/2-1, ready for the next stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            k    <= '0;
            dcnt <= '0;
        end else begin
            case (state)
                ST_ISSUE: begin
                    k    <= k + KW'(1);
                    dcnt <= '0;
                end
                ST_DRAIN: begin
                    if (dcnt == D_LAST) begin
                        dcnt <= '0;
                        if (s != S_LAST) s <= s + SW'(1);
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: begin
                    s    <= '0;
                    k    <= '0;
                    dcnt <= '0;
                end
            endcase
        end
    end

    // Group i = k >> LT selects the butterfly block; addresses are gated to zero outside ISSUE.
    always_comb begin
        lt      = LOG_N - 1 - int'(s);
        kx      = LOG_N'(k);
        tsz     = ONE << lt;
        grp     = kx >> lt;
        base    = (grp << (lt + 1)) | (kx & (tsz - ONE));
        addr_a  = rd_en ? base         : '0;
        addr_b  = rd_en ? (base + tsz) : '0;
        addr_tw = rd_en ? ((ONE << s) | grp) : '0;
    end

    ntt_addr_delay #(
        .DEPTH (D),
        .WIDTH (2 * LOG_N)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (rd_en),
        .dat_in  ({addr_a, addr_b}),
        .vld_out (bus.wr_en),
        .dat_out (wr_pair)
    );

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr_a = addr_a;
    assign bus.rd_addr_b = addr_b;
    assign bus.tw_addr   = addr_tw;
    assign bus.wr_addr_a = wr_pair[2*LOG_N-1:LOG_N];
    assign bus.wr_addr_b = wr_pair[LOG_N-1:0];
endmodule

// File: tb/tb_ntt_stage_controller.sv
// Bench for the NTT stage sequencer: small/default/N=16 instances, timing, hazard and golden NTT.
module tb_ntt_stage_controller;
    import ntt_pkg::*;

    localparam int Q  = 97;
    localparam int XS = 2 * (2 + 3);      // small: LOG_N=2, D=3
    localparam int XD = 10 * (512 + 11);  // default: LOG_N=10, D=11
    localparam int XG = 4 * (8 + 5);      // golden: LOG_N=4, D=5

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic sm_rst_n = 1'b1, df_rst_n = 1'b1, g_rst_n = 1'b1;

    ntt_stage_controller_if #(.LOG_N(2))  sm_if ();
    ntt_stage_controller_if #(.LOG_N(10)) df_if ();
    ntt_stage_controller_if #(.LOG_N(4))  g_if ();

    ntt_stage_controller #(.LOG_N(2), .BF_LATENCY(2), .MEM_LATENCY(1))
        u_sm (.clk(clk), .rst_n(sm_rst_n), .bus(sm_if.master));
    ntt_stage_controller
        u_df (.clk(clk), .rst_n(df_rst_n), .bus(df_if.master));
    ntt_stage_controller #(.LOG_N(4), .BF_LATENCY(3), .MEM_LATENCY(2))
        u_g (.clk(clk), .rst_n(g_rst_n), .bus(g_if.master));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic to_cyc(input int v);
        while (cyc < v) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int brv(input int x, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) if (x[b]) r |= 1 << (bits - 1 - b);
        return r;
    endfunction

    // ---------------- small instance monitor ----------------
    int         sm_rd_c[$];
    logic [5:0] sm_rd_v[$];
    int         sm_pnd_c[$];
    logic [3:0] sm_pnd_v[$];
    int sm_wr_n = 0, sm_align_err = 0, sm_done_n = 0, sm_done_c = 0;

    always @(negedge clk) begin
        if (sm_if.rd_en) begin
            sm_rd_c.push_back(cyc);
            sm_rd_v.push_back({sm_if.rd_addr_a, sm_if.rd_addr_b, sm_if.tw_addr});
            sm_pnd_c.push_back(cyc);
            sm_pnd_v.push_back({sm_if.rd_addr_a, sm_if.rd_addr_b});
        end
        if (sm_if.wr_en) begin
            sm_wr_n++;
            if (sm_pnd_c.size() == 0) sm_align_err++;
            else begin
                if (sm_pnd_c[0] + 3 != cyc || sm_pnd_v[0] != {sm_if.wr_addr_a, sm_if.wr_addr_b})
                    sm_align_err++;
                void'(sm_pnd_c.pop_front());
                void'(sm_pnd_v.pop_front());
            end
        end
        if (sm_if.done) begin
            sm_done_n++;
            sm_done_c = cyc;
        end
    end

    // ---------------- default instance monitor ----------------
    logic [29:0] df_exp[$];
    int df_idx = 0, df_seq_err = 0, df_wr_n = 0, df_rd_n = 0, df_busy_n = 0;
    int df_done_n = 0, df_done_c = 0, df_busy_at_done = 0;

    always @(negedge clk) begin
        if (!df_if.busy) df_idx = 0;
        if (df_if.rd_en) begin
            df_rd_n++;
            if (df_idx >= df_exp.size() ||
                df_exp[df_idx] != {df_if.rd_addr_a, df_if.rd_addr_b, df_if.tw_addr})
                df_seq_err++;
            df_idx++;
        end
        if (df_if.wr_en) df_wr_n++;
        if (df_if.busy) df_busy_n++;
        if (df_if.done) begin
            df_done_n++;
            df_done_c = cyc;
            if (df_if.busy) df_busy_at_done++;
        end
    end

    // ---------------- golden instance: behavioural RAM + butterfly ----------------
    int g_ram[16], g_init[16], psi_rev[16];
    int g_qa[$], g_qb[$];
    int g_done_n = 0, g_done_c = 0, g_wr_err = 0;

    always @(negedge clk) begin : g_mon
        int x, y, p;
        if (g_if.start && !g_if.busy && !g_if.done)
            for (int i = 0; i < 16; i++) g_ram[i] = g_init[i];
        // read before write: a read issued in the same cycle as a write sees old data
        if (g_if.rd_en) begin
            x = g_ram[g_if.rd_addr_a];
            y = g_ram[g_if.rd_addr_b];
            p = (psi_rev[g_if.tw_addr] * y) % Q;
            g_qa.push_back((x + p) % Q);
            g_qb.push_back((x - p + Q) % Q);
        end
        if (g_if.wr_en) begin
            if (g_qa.size() == 0) g_wr_err++;
            else begin
                g_ram[g_if.wr_addr_a] = g_qa.pop_front();
                g_ram[g_if.wr_addr_b] = g_qb.pop_front();
            end
        end
        if (g_if.done) begin
            g_done_n++;
            g_done_c = cyc;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int ts, d0, w0, r0, b0, psi, v;
        int pw[32];
        int g_exp[16];
        logic [5:0] sm_exp[4];

        sm_if.start = 1'b0;
        df_if.start = 1'b0;
        g_if.start  = 1'b0;

        // reference tables: canonical CT loop order and a psi of order 32 mod 97
        for (int s = 0; s < 10; s++) begin
            int m, t;
            m = 1 << s;
            t = 1024 >> (s + 1);
            for (int i = 0; i < m; i++)
                for (int j = 2 * i * t; j < 2 * i * t + t; j++)
                    df_exp.push_back({10'(j), 10'(j + t), 10'(m + i)});
        end
        psi = 0;
        for (int g = 2; g < Q && psi == 0; g++) begin
            v = 1;
            for (int e = 0; e < 16; e++) v = (v * g) % Q;
            if (v == Q - 1) psi = g;
        end
        pw[0] = 1;
        for (int e = 1; e < 32; e++) pw[e] = (pw[e-1] * psi) % Q;
        for (int m = 0; m < 16; m++) psi_rev[m] = pw[brv(m, 4)];
        sm_exp = '{6'b00_10_01, 6'b01_11_01, 6'b00_01_10, 6'b10_11_11};

        #1;
        sm_rst_n = 1'b0;
        df_rst_n = 1'b0;
        g_rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_small",
            {sm_if.busy, sm_if.done, sm_if.rd_en, sm_if.wr_en, sm_if.rd_addr_a, sm_if.rd_addr_b,
             sm_if.tw_addr, sm_if.wr_addr_a, sm_if.wr_addr_b}, 0);
        chk("reset_outputs_default",
            {df_if.busy, df_if.done, df_if.rd_en, df_if.wr_en, df_if.rd_addr_a, df_if.rd_addr_b,
             df_if.tw_addr, df_if.wr_addr_a, df_if.wr_addr_b}, 0);
        sm_rst_n = 1'b1;
        df_rst_n = 1'b1;
        g_rst_n  = 1'b1;
        @(posedge clk);
        #1;

        // small configuration: exact read sequence, write alignment, zero-slack hazard
        sm_if.start = 1'b1;
        @(posedge clk);
        #1;
        ts = cyc;
        sm_if.start = 1'b0;
        to_cyc(ts + XS + 8);
        chk("sm_read_count", sm_rd_v.size(), 4);
        chk("sm_first_read_cycle", (sm_rd_c.size() > 0) ? sm_rd_c[0] : -1, ts);
        for (int i = 0; i < 4; i++)
            chk($sformatf("sm_read_%0d_a_b_tw", i), (i < sm_rd_v.size()) ? sm_rd_v[i] : 6'bx, sm_exp[i]);
        chk("sm_done_cycle", sm_done_c, ts + XS);
        chk("sm_done_count", sm_done_n, 1);
        chk("sm_write_count", sm_wr_n, 4);
        chk("sm_write_alignment_errors", sm_align_err, 0);
        chk("sm_stage1_read_after_stage0_write",
            (sm_rd_c.size() == 4) ? sm_rd_c[2] - (sm_rd_c[1] + 3) : -1, 1);

        // default run with stray start pulses in ISSUE, DRAIN and FINISH
        d0 = df_done_n; w0 = df_wr_n; r0 = df_rd_n; b0 = df_busy_n;
        df_if.start = 1'b1;
        @(posedge clk);
        #1;
        ts = cyc;
        df_if.start = 1'b0;
        to_cyc(ts + $urandom_range(1, 500));
        df_if.start = 1'b1;
        @(posedge clk);
        #1;
        df_if.start = 1'b0;
        to_cyc(ts + 512 + $urandom_range(0, 10));
        df_if.start = 1'b1;
        @(posedge clk);
        #1;
        df_if.start = 1'b0;
        to_cyc(ts + XD);
        df_if.start = 1'b1;
        @(posedge clk);
        #1;
        df_if.start = 1'b0;
        chk("df_start_in_finish_ignored_busy", df_if.busy, 0);
        to_cyc(ts + XD + 15);
        chk("df_done_cycle", df_done_c, ts + XD);
        chk("df_done_count", df_done_n - d0, 1);
        chk("df_read_count", df_rd_n - r0, 5120);
        chk("df_write_count", df_wr_n - w0, 5120);
        chk("df_busy_cycles", df_busy_n - b0, XD);
        chk("df_busy_at_done", df_busy_at_done, 0);
        chk("df_address_sequence_errors", df_seq_err, 0);

        // async reset in stage 3 ISSUE
        df_if.start = 1'b1;
        @(posedge clk);
        #1;
        ts = cyc;
        df_if.start = 1'b0;
        to_cyc(ts + 3 * 523 + $urandom_range(5, 400));
        #2;
        df_rst_n = 1'b0;
        #1;
        chk("df_outputs_in_reset",
            {df_if.busy, df_if.done, df_if.rd_en, df_if.wr_en, df_if.rd_addr_a, df_if.rd_addr_b,
             df_if.tw_addr, df_if.wr_addr_a, df_if.wr_addr_b}, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        df_rst_n = 1'b1;
        w0 = df_wr_n;
        repeat (30) @(posedge clk);
        #1;
        chk("df_no_write_after_reset", df_wr_n - w0, 0);
        chk("df_idle_after_reset", df_if.busy, 0);

        // restart after reset completes normally
        d0 = df_done_n; w0 = df_wr_n;
        df_if.start = 1'b1;
        @(posedge clk);
        #1;
        ts = cyc;
        df_if.start = 1'b0;
        to_cyc(ts + XD + 5);
        chk("df_restart_done_cycle", df_done_c, ts + XD);
        chk("df_restart_done_count", df_done_n - d0, 1);
        chk("df_restart_write_count", df_wr_n - w0, 5120);
        chk("df_restart_address_sequence_errors", df_seq_err, 0);

        // golden N=16 transform against a direct negacyclic NTT (output in bit-reversed order)
        for (int i = 0; i < 16; i++) g_init[i] = $urandom_range(0, Q - 1);
        for (int p = 0; p < 16; p++) begin
            g_exp[p] = 0;
            for (int j = 0; j < 16; j++)
                g_exp[p] = (g_exp[p] + g_init[j] * pw[((2 * brv(p, 4) + 1) * j) % 32]) % Q;
        end
        g_if.start = 1'b1;
        @(posedge clk);
        #1;
        ts = cyc;
        g_if.start = 1'b0;
        to_cyc(ts + XG + 10);
        chk("g_done_cycle", g_done_c, ts + XG);
        chk("g_done_count", g_done_n, 1);
        chk("g_write_underflow", g_wr_err, 0);
        chk("g_pending_butterflies", g_qa.size(), 0);
        for (int p = 0; p < 16; p++)
            chk($sformatf("g_ram_%0d", p), g_ram[p], g_exp[p]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
